// File: rtl/row_sr_pkg.sv
// rtl/row_sr_pkg.sv - shared width and layout helpers for the row window shift register
package row_sr_pkg;

    // Pointer width for a DEPTH-entry ring (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold every value 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of the shift_len control, able to hold 0..max_shift.
    function automatic int len_width(input int max_shift);
        return $clog2(max_shift + 1);
    endfunction

    // Bit offset of (channel, lane) inside the flattened window bus.
    function automatic int lane_offset(input int channel, input int lane,
                                       input int max_shift, input int data_width);
        return (channel * max_shift + lane) * data_width;
    endfunction

endpackage

// File: rtl/row_sr_mem.sv
// rtl/row_sr_mem.sv - channel-wide register array with one write port and modulo read taps
//
// Ports:
//   clock        rising-edge clock (storage is intentionally not reset)
//   write_enable write write_data at write_addr on the next edge
//   write_addr   ring slot being written
//   write_data   one word per channel, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   read_base    ring slot of lane 0
//   read_data    unmasked window, lane i reads slot (read_base+i) mod DEPTH
module row_sr_mem
    import row_sr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    parameter int MAX_SHIFT  = 3,
    parameter int CHANNELS   = 1
) (
    input  logic                                     clock,
    input  logic                                     write_enable,
    input  logic [ptr_width(DEPTH)-1:0]              write_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0]           write_data,
    input  logic [ptr_width(DEPTH)-1:0]              read_base,
    output logic [CHANNELS*MAX_SHIFT*DATA_WIDTH-1:0] read_data
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH);

    logic [CHANNELS*DATA_WIDTH-1:0] storage [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            storage[write_addr] <= write_data;
        end
    end

    for (genvar lane = 0; lane < MAX_SHIFT; lane++) begin : g_tap
        logic [PW:0]   tap_sum;
        logic [PW-1:0] tap_addr;

        // base < DEPTH and lane < DEPTH, so one conditional subtract wraps it.
        assign tap_sum  = {1'b0, read_base} + (PW + 1)'(lane);
        assign tap_addr = (tap_sum >= DEPTH_P) ? PW'(tap_sum - DEPTH_P) : PW'(tap_sum);

        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            assign read_data[lane_offset(ch, lane, MAX_SHIFT, DATA_WIDTH) +: DATA_WIDTH] =
                storage[tap_addr][ch*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/row_window_sr.sv
// rtl/row_window_sr.sv - multi-channel ring shift register with a show-ahead row window
//
// Ports:
//   clock, reset       rising-edge clock; asynchronous active-low reset
//   clear              synchronous flush of pointers and count (error flags kept)
//   shift_in_enable    push one word per channel from shift_in
//   shift_out_enable   pop one word (ignored while shift_row_up is high)
//   shift_row_up       pop min(shift_len, MAX_SHIFT) words
//   shift_len          row length for shift_row_up and row_shift_rdy
//   shift_out          head word per channel
//   p_shift_out        MAX_SHIFT-lane window per channel, lanes beyond count read zero
//   count              stored words
//   full, empty, almost_full, row_shift_rdy   status from the registered count
//   overflow, underflow                        sticky error flags
module row_window_sr
    import row_sr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    parameter int MAX_SHIFT  = 3,
    parameter int CHANNELS   = 1,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     clear,
    input  logic                                     shift_in_enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0]           shift_in,
    input  logic                                     shift_out_enable,
    input  logic                                     shift_row_up,
    input  logic [len_width(MAX_SHIFT)-1:0]          shift_len,
    output logic [CHANNELS*DATA_WIDTH-1:0]           shift_out,
    output logic [CHANNELS*MAX_SHIFT*DATA_WIDTH-1:0] p_shift_out,
    output logic [count_width(DEPTH)-1:0]            count,
    output logic                                     full,
    output logic                                     empty,
    output logic                                     almost_full,
    output logic                                     row_shift_rdy,
    output logic                                     overflow,
    output logic                                     underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam int LW = len_width(MAX_SHIFT);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW:0]   DEPTH_P = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
    localparam logic [LW-1:0] MAX_L   = LW'(MAX_SHIFT);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_next;
    logic [PW-1:0] tail_next;
    logic [PW:0]   head_sum;
    logic [CW-1:0] count_next;

    logic [LW-1:0] eff_len;
    logic [CW-1:0] eff_len_c;
    logic [CW-1:0] pop_words;

    logic row_req;
    logic row_ok;
    logic row_err;
    logic single_req;
    logic single_ok;
    logic single_err;
    logic push_req;
    logic push_ok;
    logic push_err;

    logic [CHANNELS*MAX_SHIFT*DATA_WIDTH-1:0] raw_window;

    // ------------------------------------------------------------------
    // Request decode. Pop acceptance looks only at the pre-edge count, so
    // a same-cycle push can never fund a pop. A zero row length never
    // raises a request at all, which keeps it from flagging underflow.
    // ------------------------------------------------------------------
    always_comb begin
        eff_len    = (shift_len > MAX_L) ? MAX_L : shift_len;
        eff_len_c  = CW'(eff_len);

        row_req    = shift_row_up & ~clear & (eff_len != '0);
        row_ok     = row_req & (count >= eff_len_c);
        row_err    = row_req & ~row_ok;

        single_req = shift_out_enable & ~shift_row_up & ~clear;
        single_ok  = single_req & (count != '0);
        single_err = single_req & (count == '0);

        pop_words  = '0;
        if (row_ok) begin
            pop_words = eff_len_c;
        end else if (single_ok) begin
            pop_words = CW'(1);
        end

        // A full buffer still takes a push when a pop frees a slot this edge.
        push_req   = shift_in_enable & ~clear;
        push_ok    = push_req & ((count != DEPTH_C) | (pop_words != '0));
        push_err   = push_req & ~push_ok;

        // pop_words <= MAX_SHIFT <= DEPTH keeps the sum below 2*DEPTH.
        head_sum   = {1'b0, head} + (PW + 1)'(pop_words);
        head_next  = (head_sum >= DEPTH_P) ? PW'(head_sum - DEPTH_P) : PW'(head_sum);
        tail_next  = (tail == LAST_P) ? '0 : tail + PW'(1);
        count_next = count + CW'(push_ok) - pop_words;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head_next;
                count <= count_next;
                if (push_ok) begin
                    tail <= tail_next;
                end
            end
            // Request terms are already gated by clear, so a flush never
            // touches the sticky flags.
            overflow  <= overflow | push_err;
            underflow <= underflow | row_err | single_err;
        end
    end

    row_sr_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .MAX_SHIFT  (MAX_SHIFT),
        .CHANNELS   (CHANNELS)
    ) u_mem (
        .clock        (clock),
        .write_enable (push_ok),
        .write_addr   (tail),
        .write_data   (shift_in),
        .read_base    (head),
        .read_data    (raw_window)
    );

    // Lanes at or beyond count are forced to zero; storage is never reset,
    // so this is what hides stale words after reset, clear or pops.
    for (genvar lane = 0; lane < MAX_SHIFT; lane++) begin : g_lane
        logic lane_valid;
        assign lane_valid = (count > CW'(lane));

        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            localparam int OFS = lane_offset(ch, lane, MAX_SHIFT, DATA_WIDTH);
            assign p_shift_out[OFS +: DATA_WIDTH] =
                lane_valid ? raw_window[OFS +: DATA_WIDTH] : '0;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_head
        assign shift_out[ch*DATA_WIDTH +: DATA_WIDTH] =
            p_shift_out[lane_offset(ch, 0, MAX_SHIFT, DATA_WIDTH) +: DATA_WIDTH];
    end

    assign full          = (count == DEPTH_C);
    assign empty         = (count == '0);
    assign almost_full   = (int'(count) >= AF_LEVEL);
    assign row_shift_rdy = (eff_len != '0) & (count >= eff_len_c);

endmodule

// File: doc/row_window_sr.md
ROW_WINDOW_SR -- requirements
Module: row_window_sr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per word per channel.
REQ-002 SHALL have parameter DEPTH, default 10: words per channel, any value >= 2, not restricted to a power of two.
REQ-003 SHALL have parameter MAX_SHIFT, default 3: parallel window lanes per channel; 1 <= MAX_SHIFT <= DEPTH.
REQ-004 SHALL have parameter CHANNELS, default 1: parallel channels sharing one set of pointers and controls.
REQ-005 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full threshold.
REQ-006 SHALL have port clock, input, 1: rising-edge clock.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port clear, input, 1: synchronous flush.
REQ-009 SHALL have port shift_in_enable, input, 1: push one word per channel.
REQ-010 SHALL have port shift_in, input, CHANNELS*DATA_WIDTH: push data; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port shift_out_enable, input, 1: pop one word.
REQ-012 SHALL have port shift_row_up, input, 1: pop a row of shift_len words.
REQ-013 SHALL have port shift_len, input, clog2(MAX_SHIFT+1): row length for shift_row_up and row_shift_rdy.
REQ-014 SHALL have port shift_out, output, CHANNELS*DATA_WIDTH: head word per channel, show-ahead.
REQ-015 SHALL have port p_shift_out, output, CHANNELS*MAX_SHIFT*DATA_WIDTH: window; channel c, lane i = word head+i at [(c*MAX_SHIFT+i)*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port count, output, clog2(DEPTH+1): stored word count.
REQ-017 SHALL have status outputs, each 1 bit: full (count==DEPTH), empty (count==0), almost_full (count>=AF_LEVEL), row_shift_rdy (count>=eff_len and eff_len>0).
REQ-018 SHALL have error outputs, each 1 bit: overflow and underflow, both sticky.

Function
REQ-019 SHALL define eff_len = min(shift_len, MAX_SHIFT); shift_len=0 makes shift_row_up a silent no-op.
REQ-020 SHALL decode pop priority: clear > shift_row_up > shift_out_enable; shift_out_enable is ignored in any cycle shift_row_up is asserted.
REQ-021 SHALL accept a push if count<DEPTH, or if count==DEPTH and a pop of >=1 word is accepted the same cycle; otherwise drop it and set overflow.
REQ-022 SHALL accept a single pop only if count>=1 and a row pop only if count>=eff_len; rejected pops change nothing and set underflow.
REQ-023 SHALL evaluate pop acceptance on pre-edge count; a same-cycle push never funds a pop.
REQ-024 SHALL update count as count + push_acc - pop_words at the edge; head and tail wrap modulo DEPTH.
REQ-025 SHALL present a pushed word on shift_out/p_shift_out in the cycle after the push edge, with no added latency.
REQ-026 SHALL drive shift_out and p_shift_out combinationally from storage and head; any lane i>=count reads as zero, so an empty buffer outputs all zeros.
REQ-027 SHALL derive full, empty, almost_full and row_shift_rdy from the registered count; row_shift_rdy tracks shift_len combinationally.
REQ-028 SHALL, on clear, zero head, tail and count at the next edge, ignore same-cycle push and pop, and leave overflow/underflow unchanged.
REQ-029 SHALL give all channels identical pointer behaviour; channels differ only in data.

Reset
REQ-030 SHALL, on reset low, asynchronously zero head, tail, count, overflow and underflow; outputs read empty=1, full=0, row_shift_rdy=0, all data zero.
REQ-031 SHALL leave storage unreset; the zero-masking in REQ-026 makes stale contents invisible, including after reset mid-transfer.

Structure
REQ-032 SHALL place the shared package row_sr_pkg constants there: pointer/count width functions and the lane-offset function used by REQ-015.
REQ-033 SHALL use one sub-module, row_sr_mem: CHANNELS-wide register array with one write port and MAX_SHIFT modulo-DEPTH read taps.

Verification (DATA_WIDTH=8, DEPTH=10, MAX_SHIFT=3, CHANNELS=1 unless stated; pushed data 0,1,2,...)
REQ-034 SHALL cover: 9 pushes -> count=9, almost_full=1, full=0; 10th -> full=1; 11th without pop -> count=10, overflow=1, head still 0.
REQ-035 SHALL cover: full, one shift_out_enable -> shift_out 0->1, count=9; shift_row_up and shift_out_enable together with shift_len=3 -> p_shift_out {1,2,3}->{4,5,6}, count=6.
REQ-036 SHALL cover: count=2, shift_len=3, shift_row_up -> ignored, row_shift_rdy=0, underflow=1; shift_len=2 -> accepted, count=0, outputs zero.
REQ-037 SHALL cover: empty, push+pop same cycle -> count=1, underflow=1; count=10, push+pop -> count=10, overflow stays 0; 25 cycles push+pop -> in-order data across wrap.
REQ-038 SHALL cover: CHANNELS=2, ch1 data = ch0+100 -> window lanes correct per channel after row pops with shift_len 1,2,3.
REQ-039 SHALL cover: reset low asynchronously mid-stream (count=5) -> empty=1, count=0, outputs zero before the next edge; clear at count=7 -> count=0 next edge, flags retained.
